// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared state encoding and constants for the instruction-fetch stage
package if_pkg;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DROP  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_incr;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry holding register for a fetch that lands during a stall
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      full <= 1'b0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, single-outstanding imem port, stall skid, redirect squash
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = if_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_incr,
  output logic [31:0] instr,
  output logic [25:0] jumpoffset,
  output logic        valid
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] pc_next_seq;
  logic        fetch_hit;
  logic        skid_full;
  fetch_word_t skid_q;

  assign pc_next_seq = pc + PC_STEP;
  assign fetch_hit   = (state == FETCH) && imem_ack && !redirect;

  // While draining a squashed request the port must keep presenting the old address.
  assign imem_req  = !rst && ((state == FETCH) || (state == DROP));
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (fetch_hit && stall),
    .unload (skid_full && !stall),
    .clear  (redirect),
    .din    ({imem_rdata, pc_next_seq}),
    .dout   (skid_q),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (!imem_ack) begin
              state     <= DROP;
              drop_addr <= pc;
            end
          end else if (imem_ack) begin
            pc <= pc_next_seq;
            if (stall) state <= WAIT;
          end
        end
        DROP: begin
          if (redirect) pc <= redirect_pc;
          if (imem_ack) state <= FETCH;
        end
        WAIT: begin
          if (redirect) pc <= redirect_pc;
          if (redirect || !stall) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Redirect squashes whatever would have been presented, even under stall.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      instr   <= NOP_INSTR;
      pc_incr <= '0;
      valid   <= 1'b0;
    end else if (!stall) begin
      if (fetch_hit) begin
        instr   <= imem_rdata;
        pc_incr <= pc_next_seq;
        valid   <= 1'b1;
      end else if (skid_full) begin
        instr   <= skid_q.instr;
        pc_incr <= skid_q.pc_incr;
        valid   <= 1'b1;
      end else begin
        instr   <= NOP_INSTR;
        pc_incr <= '0;
        valid   <= 1'b0;
      end
    end
  end

  assign jumpoffset = instr[25:0];

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized scoreboard bench for if_fetch
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, pc_incr, instr;
  logic [25:0] jumpoffset;
  logic        imem_req, valid;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc_incr, w_instr;
  logic [25:0] w_jumpoffset;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit mon_en = 1'b0;

  logic [63:0] exp_q[$];
  logic [31:0] want;
  logic [31:0] pend_addr;
  bit          stale;
  bit          pend;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hA000_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_incr(pc_incr), .instr(instr), .jumpoffset(jumpoffset), .valid(valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_rdata),
    .pc_incr(w_pc_incr), .instr(w_instr), .jumpoffset(w_jumpoffset), .valid(w_valid)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: registered outputs compared against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (valid === 1'b1) begin
          check("q_nonempty_on_valid", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("instr", instr, exp_q[0][63:32]);
            check("pc_incr", pc_incr, exp_q[0][31:0]);
          end
        end else begin
          check("valid_known", 32'(valid), 32'd0);
          check("bubble_instr", instr, 32'h0);
          check("bubble_pc_incr", pc_incr, 32'h0);
        end
        check("jumpoffset", 32'(jumpoffset), 32'(instr[25:0]));
      end
    end
  end

  // Drive one cycle of inputs and advance the architectural model to the coming edge.
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rpc, input int ack_pct);
    @(negedge clk);
    rst = r;
    stall = s;
    redirect = rd;
    redirect_pc = rpc;
    #1;
    imem_ack = r ? 1'b1 : (imem_req && (int'($urandom_range(0, 99)) < ack_pct));
    #1;
    if (r) begin
      check("req_in_reset", 32'(imem_req), 32'd0);
      exp_q.delete();
      want  = 32'h0;
      stale = 1'b0;
      pend  = 1'b0;
    end else begin
      if (pend) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, pend_addr);
      end
      if (valid === 1'b1 && !s && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (rd) begin
        exp_q.delete();
        stale = imem_req && !imem_ack;
        want  = rpc;
      end else if (imem_req && imem_ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          check("fetch_addr", imem_addr, want);
          exp_q.push_back({mem_word(want), want + 32'd4});
          want = want + 32'd4;
        end
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF8;
    return 32'($urandom_range(0, 1023)) << 2;
  endfunction

  task automatic random_phase(input int n, input int stall_pct, input int redir_pct, input int ack_pct);
    for (int i = 0; i < n; i++) begin
      step(1'b0, int'($urandom_range(0, 99)) < stall_pct, int'($urandom_range(0, 99)) < redir_pct,
           rand_target(), ack_pct);
    end
  endtask

  initial begin
    int nvalid;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 100);
    step(1'b1, 1'b0, 1'b0, 32'h0, 100);
    check("reset_instr", instr, 32'h0);
    check("reset_pc_incr", pc_incr, 32'h0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_jumpoffset", 32'(jumpoffset), 32'h0);
    mon_en = 1'b1;

    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 100);
      if (i == 0) check("first_req_addr", imem_addr, 32'h0);
      if (i >= 1 && valid === 1'b1) nvalid++;
      if (i == 1) begin
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_pc_incr", w_pc_incr, 32'h0);
        check("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
        check("wrap_second_addr", w_addr, 32'h0);
      end
      if (i == 2) check("wrap_pc_incr2", w_pc_incr, 32'h4);
    end
    check("zero_wait_throughput", 32'(nvalid), 32'd19);

    random_phase(1500, 25, 6, 50);
    step(1'b1, 1'b0, 1'b0, 32'h0, 100);
    random_phase(1500, 50, 10, 30);
    random_phase(500, 0, 0, 100);

    check("delivered_enough", 32'(delivered > 200), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
